fp_mult_result_stage: RTL and testbench
=======================================

Name: fp_mult_result_stage

Overview:
- Registered output stage directly downstream of the combinational single-precision FP multiplier.
- Captures each operand pair (a, b) with its 32-bit product and classifies the result: NaN-class, zero-class, exponent overflow or exponent underflow.
- Saturates the product word on overflow/underflow and buffers results in a small valid/ready FIFO, so the consumer can stall without re-driving the multiplier.
- Keeps sticky exception flags for software readback.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
CNT_W, 3, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  a, b and prod are valid this cycle.
in_ready  output  1  stage can accept an entry this cycle.
a  input  32  operand A, the same word fed to the multiplier.
b  input  32  operand B, the same word fed to the multiplier.
prod  input  32  combinational multiplier output for (a, b).
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_data  output  32  corrected product of the head entry.
out_flags  output  4  flags of the head entry, {nan, ovf, unf, zero}.
count  output  CNT_W  current occupancy.
clr_flags  input  1  clears the sticky flags.
sticky_flags  output  4  OR of the flags of all accepted entries since the last clear, {nan, ovf, unf, zero}.

Behaviour:
- Reset values (asynchronous on rst_n=0): count=0, out_valid=0, out_data=0, out_flags=0, sticky_flags=0, read/write pointers=0, in_ready=1 once rst_n=1.
- Reset mid-operation discards all entries immediately; no partial update.
- Handshake:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH), registered-count based; a full FIFO does not accept on the cycle of a pop (no pass-through).
  - out_valid = (count != 0).
  - out_data/out_flags are driven from the head entry and stay stable while out_valid=1 and out_ready=0.
- Latency: push at edge N makes the entry visible at the head after edge N when the FIFO was empty. There is no combinational in->out path.
- Count update:
  - push&pop: count unchanged.
  - push only: +1.
  - pop only: -1.
  - Both pointers wrap modulo DEPTH.
  - pop with count=0 and push with count=DEPTH cannot occur (gated by valid/ready).
- Classification, combinational on inputs and stored with the entry:
  - ea=a[30:23], eb=b[30:23].
  - nan = (ea==8'hFF) | (eb==8'hFF).
  - zero = ~nan & ((ea==0) | (eb==0)).
  - e = ea + eb - 127, as a 10-bit signed value.
  - sh = (prod[30:23] == e[7:0] + 1).
  - et = e + sh.
  - When ~nan & ~zero: ovf = (et >= 255); unf = (et <= 0). Otherwise ovf = unf = 0.
- Correction of the stored word:
  - ovf: {prod[31], 8'hFF, 23'b0} (signed infinity).
  - unf: 32'h0000_0000.
  - Otherwise prod is stored unchanged (NaN/zero words from the multiplier pass through).
- Sticky flags:
  - On each push, sticky_flags |= the entry's flags.
  - clr_flags=1 clears all four bits at the edge.
  - If a push coincides with clr_flags, sticky_flags = that push's flags (the new event is not lost).

Test Plan:
- Reset/normal: a=3F800000 (1.0), b=40000000 (2.0), prod=40000000, in_valid for 1 cycle, out_ready=1 -> out_valid high the next cycle, out_data=40000000, out_flags=0, count returns to 0 after the pop.
- Overflow: a=7F000000, b=7F000000, prod=7E800000 (wrapped exponent) -> out_data=7F800000, out_flags=4'b0100, sticky_flags=4'b0100; with a[31]=1, out_data=FF800000.
- Underflow and NaN/zero:
  - a=00800000, b=00800000 -> out_data=00000000, flags=4'b0010.
  - a=7F800000 -> flags=4'b1000, prod passed through.
  - a=00000000 -> flags=4'b0001.
- Backpressure: out_ready=0, push 5 entries -> in_ready drops after the 4th, count=4, the 5th is held by the source; raise out_ready -> FIFO drains in order, count 4→0.
- Simultaneous events:
  - push&pop at count=2 keeps count=2.
  - clr_flags with an overflow push leaves sticky_flags=4'b0100.
  - rst_n low while count=3 -> count=0 and out_valid=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fp_mult_result_stage.sv
// Registered result stage for the single-precision multiplier: it classifies and
// saturates each product, then queues it in a small valid/ready FIFO with sticky flags.
module fp_mult_result_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [31:0]      prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] count,
    input  logic             clr_flags,
    output logic [3:0]       sticky_flags
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [3:0]  flags;   // {nan, ovf, unf, zero}
        logic [31:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    logic [7:0]        ea;
    logic [7:0]        eb;
    logic signed [9:0] e;
    logic signed [9:0] et;
    logic [7:0]        e_inc;
    logic              sh;
    logic              nan;
    logic              zero;
    logic              ovf;
    logic              unf;
    entry_t            new_entry;

    // NOTE: every signal written in always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        ea        = a[30:23];
        eb        = b[30:23];
        nan       = (ea == 8'hFF) | (eb == 8'hFF);
        zero      = ~nan & ((ea == 8'h00) | (eb == 8'h00));
        e         = {2'b00, ea} + {2'b00, eb} - 10'd127;
        // The multiplier bumps the exponent when the mantissa product reaches 2.0.
        e_inc     = e[7:0] + 8'd1;
        sh        = (prod[30:23] == e_inc);
        et        = e + {9'b0, sh};
        ovf       = ~nan & ~zero & (et >= 10'sd255);
        unf       = ~nan & ~zero & (et <= 10'sd0);
        new_entry = '{flags: {nan, ovf, unf, zero}, data: prod};
        if (ovf) begin
            new_entry.data = {prod[31], 8'hFF, 23'b0};
        end else if (unf) begin
            new_entry.data = 32'h0000_0000;
        end
    end

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is forced to zero when empty so outputs are defined without resetting storage.
    assign out_data  = out_valid ? mem[rd_ptr].data  : 32'h0000_0000;
    assign out_flags = out_valid ? mem[rd_ptr].flags : 4'b0000;

    // NOTE: the storage array is deliberately not reset; entries are only ever read
    // behind out_valid, and leaving it unreset keeps it a plain RAM-style array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            sticky_flags <= 4'b0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // A clear coinciding with a push keeps that push's event.
            if (clr_flags) begin
                sticky_flags <= push ? new_entry.flags : 4'b0000;
            end else if (push) begin
                sticky_flags <= sticky_flags | new_entry.flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_result_stage.sv
// Scoreboard bench for fp_mult_result_stage: the driver queues hand-computed
// expected entries, a monitor pops and compares them whenever the DUT pops.
module tb_fp_mult_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic        clr_flags;
    logic [3:0]  sticky_flags;

    int total = 0;
    int bad   = 0;

    logic [35:0] sb_q [$];   // {flags, data}

    fp_mult_result_stage #(.DEPTH(4), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .prod         (prod),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .count        (count),
        .clr_flags    (clr_flags),
        .sticky_flags (sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop happens at the posedge after this negedge sample.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    logic [35:0] exp_e;
                    exp_e = sb_q.pop_front();
                    check("out_data",  64'(out_data),  64'(exp_e[31:0]));
                    check("out_flags", 64'(out_flags), 64'(exp_e[35:32]));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_w, input logic [31:0] tp,
                        input logic [31:0] ed, input logic [3:0] ef);
        bit acc;
        acc      = 1'b0;
        a        = ta;
        b        = tb_w;
        prod     = tp;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({ef, ed});
                acc = 1'b1;
                break;
            end
        end
        check("push_accepted", 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (count == 3'd0 && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        prod      = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        #22;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count",     64'(count),        64'd0);
        check("rst_out_valid", 64'(out_valid),    64'd0);
        check("rst_in_ready",  64'(in_ready),     64'd1);
        check("rst_out_data",  64'(out_data),     64'd0);
        check("rst_out_flags", 64'(out_flags),    64'd0);
        check("rst_sticky",    64'(sticky_flags), 64'd0);
        @(posedge clk);
        #1;

        // Normal products, including the mantissa-carry case.
        out_ready = 1'b1;
        send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000);
        @(negedge clk);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        send(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 32'h4010_0000, 4'b0000);
        wait_empty();
        check("sticky_normal", 64'(sticky_flags), 64'd0);

        // Overflow saturates to signed infinity.
        send(32'h7F00_0000, 32'h7F00_0000, 32'h7E80_0000, 32'h7F80_0000, 4'b0100);
        send(32'hFF00_0000, 32'h7F00_0000, 32'hFE80_0000, 32'hFF80_0000, 4'b0100);
        wait_empty();
        check("sticky_ovf", 64'(sticky_flags), 64'd4);

        clr_flags = 1'b1;
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        check("sticky_cleared", 64'(sticky_flags), 64'd0);

        // Underflow, NaN, zero and the et=0/et=1 boundary.
        send(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 4'b0010);
        send(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h7F80_0000, 4'b1000);
        send(32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001);
        send(32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000);
        send(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 32'h0080_0000, 4'b0000);
        send(32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 32'h0000_0000, 4'b0010);
        wait_empty();
        check("sticky_mix", 64'(sticky_flags), 64'hB);

        // et=254 passes, et=255 (reached via the carry) saturates.
        send(32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 32'h7F00_0000, 4'b0000);
        send(32'h7F40_0000, 32'h3FC0_0000, 32'h7F90_0000, 32'h7F80_0000, 4'b0100);
        wait_empty();
        check("sticky_all", 64'(sticky_flags), 64'hF);

        // Clear coinciding with an overflow push keeps the new event.
        clr_flags = 1'b1;
        send(32'h7F00_0000, 32'h7F00_0000, 32'h7E80_0000, 32'h7F80_0000, 4'b0100);
        clr_flags = 1'b0;
        check("sticky_clr_push", 64'(sticky_flags), 64'd4);
        wait_empty();

        // Backpressure: fill, hold the fifth, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h3F80_0000, 32'h3F80_0000 | 32'(i + 1), 32'h3F80_0000 | 32'(i + 1),
                 32'h3F80_0000 | 32'(i + 1), 4'b0000);
        end
        fork
            send(32'h3F80_0000, 32'h3F80_0005, 32'h3F80_0005, 32'h3F80_0005, 4'b0000);
            begin
                repeat (2) @(negedge clk);
                check("full_count",    64'(count),    64'd4);
                check("full_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("full_pop_no_passthru", 64'(in_ready), 64'd0);
            end
        join
        wait_empty();

        // Simultaneous push and pop at count=2.
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h3F80_0011, 32'h3F80_0011, 32'h3F80_0011, 4'b0000);
        send(32'h3F80_0000, 32'h3F80_0012, 32'h3F80_0012, 32'h3F80_0012, 4'b0000);
        out_ready = 1'b1;
        send(32'h3F80_0000, 32'h3F80_0013, 32'h3F80_0013, 32'h3F80_0013, 4'b0000);
        out_ready = 1'b0;
        @(negedge clk);
        check("push_pop_count", 64'(count), 64'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_empty();

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h7F00_0000, 32'h7F00_0000, 32'h7E80_0000, 32'h7F80_0000, 4'b0100);
        end
        @(negedge clk);
        check("pre_reset_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_rst_count",     64'(count),        64'd0);
        check("async_rst_out_valid", 64'(out_valid),    64'd0);
        check("async_rst_out_data",  64'(out_data),     64'd0);
        check("async_rst_sticky",    64'(sticky_flags), 64'd0);
        #6;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 4'b0000);
        wait_empty();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
